// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier with HI/LO result registers.
// Handles signed (MULT) and unsigned (MULTU) multiplies and accepts MTHI/MTLO writes.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               neg_next;
  logic [2*WIDTH-1:0] product;

  // Handshake: start_mult is taken only while busy=0 (IDLE); a start seen while
  // busy is dropped. Completion is signalled by a one-cycle done pulse that
  // coincides with the new hi/lo values; there is no back-pressure on done.

  // Magnitudes are treated as unsigned so |0x80..0| stays representable.
  always_comb begin
    abs_a    = (mult_sign && src_a[WIDTH-1]) ? (~src_a + ONE_W) : src_a;
    abs_b    = (mult_sign && src_b[WIDTH-1]) ? (~src_b + ONE_W) : src_b;
    neg_next = mult_sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    product  = neg ? (~acc + ONE_2W) : acc;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_mult) state_next = S_RUN;
      S_RUN:  if (count == LAST_BIT) state_next = S_FIN;
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_mult) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= neg_next;
            acc    <= '0;
            count  <= '0;
          end
        end
        S_RUN: begin
          // Shift-register form: multiplicand moves left as multiplier bits retire.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        S_FIN: begin
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A product landing at FIN outranks a same-edge MTHI/MTLO write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (state == S_FIN)  hi <= product[2*WIDTH-1:WIDTH];
      else if (hi_we)      hi <= wdata;
      if (state == S_FIN)  lo <= product[WIDTH-1:0];
      else if (lo_we)      lo <= wdata;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: directed vector table, random operands against a
// 64-bit arithmetic model, and hand-written reset/busy/MTHI/MTLO sequences.
module tb_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult;
  logic         mult_sign;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full-precision product from plain integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Starts a multiply at the next edge and waits for done; called #1 after an edge.
  task automatic do_mult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rh, output logic [W-1:0] rl,
                         output int cyc, output bit ok);
    int guard;
    start_mult = 1'b1;
    mult_sign  = s;
    src_a      = a;
    src_b      = b;
    @(posedge clk); #1;
    start_mult = 1'b0;
    src_a      = $urandom;
    src_b      = $urandom;
    mult_sign  = 1'($urandom_range(0, 1));
    cyc   = 0;
    guard = 0;
    while (!done && guard < 100) begin
      if (busy) cyc++;
      guard++;
      @(posedge clk); #1;
    end
    ok = done;
    rh = hi;
    rl = lo;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done within %0d cycles", guard);
    end else begin
      check("busy_low_with_done", 64'(busy), 64'd0);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] rh;
    logic [W-1:0] rl;
    logic [63:0]  exp_p;
    int           cyc;
    bit           ok;
    int           seen;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

    // Clock/reset
    reset = 1'b1; start_mult = 1'b0; mult_sign = 1'b0;
    src_a = '0; src_b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // Directed vectors
    foreach (vecs[i]) begin
      do_mult(vecs[i].sign, vecs[i].a, vecs[i].b, rh, rl, cyc, ok);
      if (ok) begin
        check($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].ehi));
        check($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].elo));
        check($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(W + 1));
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
    end

    // Random operands against the model, issued back-to-back from the done cycle
    for (int i = 0; i < 24; i++) begin
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      s = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      exp_p = ref_prod(s, a, b);
      do_mult(s, a, b, rh, rl, cyc, ok);
      if (ok) begin
        check($sformatf("rand%0d_hi", i), 64'(rh), 64'(exp_p[63:32]));
        check($sformatf("rand%0d_lo", i), 64'(rl), 64'(exp_p[31:0]));
        check($sformatf("rand%0d_latency", i), 64'(cyc), 64'(W + 1));
      end
    end

    // Reset mid-RUN abandons the operation with no done pulse
    start_mult = 1'b1; mult_sign = 1'b0; src_a = 32'd1000; src_b = 32'd3000;
    @(posedge clk); #1 start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("midrun_reset_hi", 64'(hi), 64'd0);
    check("midrun_reset_lo", 64'(lo), 64'd0);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midrun_reset_no_activity", 64'(seen), 64'd0);
    do_mult(1'b0, 32'd1000, 32'd3000, rh, rl, cyc, ok);
    if (ok) begin
      check("post_reset_lo", 64'(rl), 64'd3000000);
      check("post_reset_hi", 64'(rh), 64'd0);
    end

    // Start while busy is ignored; operands may change during RUN
    start_mult = 1'b1; mult_sign = 1'b1; src_a = 32'hFFFF_F000; src_b = 32'd5678;
    exp_p = ref_prod(1'b1, 32'hFFFF_F000, 32'd5678);
    @(posedge clk); #1 start_mult = 1'b0;
    repeat (5) @(posedge clk);
    #1 start_mult = 1'b1; src_a = 32'h1234_5678; src_b = 32'h0000_0003; mult_sign = 1'b0;
    @(posedge clk); #1 start_mult = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      src_a = $urandom;
      @(posedge clk); #1;
      seen++;
    end
    check("ignore_done_seen", 64'(done), 64'd1);
    check("ignore_done_latency", 64'(seen + 6), 64'(W + 1));
    check("ignore_hi", 64'(hi), 64'(exp_p[63:32]));
    check("ignore_lo", 64'(lo), 64'(exp_p[31:0]));
    @(posedge clk); #1;
    check("ignore_no_second_op", 64'(busy), 64'd0);

    // MTHI in IDLE leaves LO alone
    rl = lo;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1 hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_lo_kept", 64'(lo), 64'(rl));
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1 lo_we = 1'b0; hi_we = 1'b0;
    check("mthilo_hi", 64'(hi), 64'hCAFE_F00D);
    check("mthilo_lo", 64'(lo), 64'hCAFE_F00D);

    // MTLO at the FIN edge loses to the product
    start_mult = 1'b1; mult_sign = 1'b0; src_a = 32'd77; src_b = 32'd1001;
    @(posedge clk); #1 start_mult = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("fin_cycle_hi_held", 64'(hi), 64'hCAFE_F00D);
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    @(posedge clk); #1 lo_we = 1'b0;
    check("fin_tie_done", 64'(done), 64'd1);
    check("fin_tie_lo", 64'(lo), 64'd77077);
    check("fin_tie_hi", 64'(hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
